div_seq: RTL

Parametrised sequential unsigned divider: WIDTH-bit dividend by WIDTH-bit divisor, one restoring-division step per clock, producing quotient and remainder. Successor to the 8-bit combinational array divider. It trades the full array for a single step cell reused WIDTH times, adds valid/ready handshakes on both sides and flags divide-by-zero explicitly. It sits between register-sourced operands and any consumer that tolerates multi-cycle latency and backpressure.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 21 ++
 rtl/div_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constant helpers for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

    // Ceiling log2, usable in constant expressions for sizing the step counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] next_rem,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // Since rem < divisor, a borrow always leaves trial[WIDTH] set and a fit always clears it.
    always_comb begin
        trial    = {rem, din} - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        next_rem = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], din};
    end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider: one restoring step per clock, valid/ready on both sides,
// explicit divide-by-zero flag.
module div_seq
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned     CntW    = clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem     (rem_q),
        .din     (dvd_q[WIDTH-1]),
        .divisor (dvs_q),
        .next_rem(step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        // Same result the array divider produced for a zero divisor.
                        dvd_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                // Quotient bits fill the dividend register from the LSB as its MSBs are consumed.
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                rem_d = step_rem;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state_q == IDLE);
        out_valid   = (state_q == DONE);
        quotient    = dvd_q;
        remainder   = rem_q;
        div_by_zero = dbz_q;
    end

endmodule
